// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: result-word layout and divisor floor.
package uart_pkg;

   localparam int RX_WORD_W    = 10;
   localparam int RXW_DATA_MSB = 7;
   localparam int RXW_PERR     = 8;
   localparam int RXW_FERR     = 9;
   localparam int RX_DIV_MIN   = 4;

   // Packed view of one FSM result word; field order matches the RXW_* indices.
   typedef struct packed {
      logic                  ferr;
      logic                  perr;
      logic [RXW_DATA_MSB:0] data;
   } rx_word_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and a sticky overrun flag.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = RX_WORD_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   input  logic             clr_ovr,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic             ovr
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             ovr_q, ovr_d;
   logic             do_pop, do_push;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign ovr     = ovr_q;

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      ovr_d    = ovr_q;
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (push && full && !do_pop) begin
         ovr_d = 1'b1;
      end else if (clr_ovr) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovr_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovr_q    <= ovr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: pin synchroniser, bit-strobe timer, result FIFO and error counters.
// Define UART_RX_ERR_CNT_EN to build the saturating parity/framing error counters.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RXD,
   input  logic [DIV_W-1:0]     DIV,
   output logic                 RXD_RG,
   output logic                 RX_CE,
   input  logic                 RXCT_R,
   input  logic [RX_WORD_W-1:0] RX_DATA_T,
   input  logic                 RX_DATA_EN,
   input  logic                 RD_EN,
   output logic                 RD_VALID,
   output logic [7:0]           RD_DATA,
   output logic                 RD_PERR,
   output logic                 RD_FERR,
   output logic                 FULL,
   output logic                 OVR,
   input  logic                 CLR_OVR,
   output logic [7:0]           PERR_CNT,
   output logic [7:0]           FERR_CNT,
   input  logic                 CLR_CNT
);

   logic [1:0]           sync_q, sync_d;
   logic [DIV_W-1:0]     cnt_q, cnt_d;
   logic [DIV_W-1:0]     div_e;
   logic                 rx_ce;
   logic [RX_WORD_W-1:0] head_raw;
   logic                 fifo_empty;
   rx_word_t             head;

   always_comb begin
      sync_d = {sync_q[0], RXD};
   end

   // Reload with half a bit period while held, so the first strobe lands mid start bit.
   always_comb begin
      div_e = (DIV < DIV_W'(RX_DIV_MIN)) ? DIV_W'(RX_DIV_MIN) : DIV;
      cnt_d = cnt_q;
      rx_ce = 1'b0;
      if (RXCT_R) begin
         cnt_d = (div_e >> 1) - DIV_W'(1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - DIV_W'(1);
      end else begin
         rx_ce = 1'b1;
         cnt_d = div_e - DIV_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q <= 2'b11;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
      end
   end

   assign RXD_RG = sync_q[1];
   // The zeroed timer would otherwise strobe while reset is held.
   assign RX_CE  = rx_ce & ~RST;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (RX_WORD_W)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .push    (RX_DATA_EN),
      .wr_data (RX_DATA_T),
      .pop     (RD_EN),
      .clr_ovr (CLR_OVR),
      .rd_data (head_raw),
      .empty   (fifo_empty),
      .full    (FULL),
      .ovr     (OVR)
   );

   assign head     = rx_word_t'(head_raw);
   assign RD_VALID = !fifo_empty;
   assign RD_DATA  = head.data;
   assign RD_PERR  = head.perr;
   assign RD_FERR  = head.ferr;

`ifdef UART_RX_ERR_CNT_EN
   logic [7:0] perr_cnt_q, perr_cnt_d;
   logic [7:0] ferr_cnt_q, ferr_cnt_d;

   // Counted at the FSM output, so words later dropped by overrun are still included.
   always_comb begin
      perr_cnt_d = perr_cnt_q;
      ferr_cnt_d = ferr_cnt_q;
      if (CLR_CNT) begin
         perr_cnt_d = 8'd0;
         ferr_cnt_d = 8'd0;
      end else if (RX_DATA_EN) begin
         if (RX_DATA_T[RXW_PERR] && (perr_cnt_q != 8'hFF)) begin
            perr_cnt_d = perr_cnt_q + 8'd1;
         end
         if (RX_DATA_T[RXW_FERR] && (ferr_cnt_q != 8'hFF)) begin
            ferr_cnt_d = ferr_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         perr_cnt_q <= 8'd0;
         ferr_cnt_q <= 8'd0;
      end else begin
         perr_cnt_q <= perr_cnt_d;
         ferr_cnt_q <= ferr_cnt_d;
      end
   end

   assign PERR_CNT = perr_cnt_q;
   assign FERR_CNT = ferr_cnt_q;
`else
   logic unused_clr_cnt;

   assign unused_clr_cnt = CLR_CNT;
   assign PERR_CNT       = 8'd0;
   assign FERR_CNT       = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomised self-checking bench for uart_rx_ctrl against a cycle-indexed behavioural model.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        RXD = 1'b1;
   logic [15:0] DIV = 16'd16;
   logic        RXCT_R = 1'b1;
   logic [9:0]  RX_DATA_T = '0;
   logic        RX_DATA_EN = 1'b0;
   logic        RD_EN = 1'b0;
   logic        CLR_OVR = 1'b0;
   logic        CLR_CNT = 1'b0;
   logic        RXD_RG, RX_CE, RD_VALID, RD_PERR, RD_FERR, FULL, OVR;
   logic [7:0]  RD_DATA, PERR_CNT, FERR_CNT;

   int checkCount = 0;
   int passCount  = 0;

   // Model state: expected FIFO contents, absolute cycle of the next strobe, pin history.
   logic [9:0] fifoQ[$];
   bit         rxdHist[$];
   bit         ovrM;
   int         perrM, ferrM;
   int         cyc = 0;
   int         nextCe = 0;

   uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
      .CLK(CLK), .RST(RST), .RXD(RXD), .DIV(DIV), .RXD_RG(RXD_RG), .RX_CE(RX_CE),
      .RXCT_R(RXCT_R), .RX_DATA_T(RX_DATA_T), .RX_DATA_EN(RX_DATA_EN), .RD_EN(RD_EN),
      .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_PERR(RD_PERR), .RD_FERR(RD_FERR),
      .FULL(FULL), .OVR(OVR), .CLR_OVR(CLR_OVR), .PERR_CNT(PERR_CNT), .FERR_CNT(FERR_CNT),
      .CLR_CNT(CLR_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
      else
         passCount++;
   endtask

   task automatic checkAllOutputs();
      checkOutput("rxd_rg", 32'(RXD_RG), 32'(rxdHist[rxdHist.size()-2]));
      checkOutput("rx_ce", 32'(RX_CE), 32'(!RXCT_R && (cyc == nextCe)));
      checkOutput("rd_valid", 32'(RD_VALID), 32'(fifoQ.size() != 0));
      checkOutput("full", 32'(FULL), 32'(fifoQ.size() == DEPTH));
      checkOutput("ovr", 32'(OVR), 32'(ovrM));
      checkOutput("perr_cnt", 32'(PERR_CNT), 32'(perrM));
      checkOutput("ferr_cnt", 32'(FERR_CNT), 32'(ferrM));
      if (fifoQ.size() != 0) begin
         checkOutput("rd_data", 32'(RD_DATA), 32'(fifoQ[0][7:0]));
         checkOutput("rd_perr", 32'(RD_PERR), 32'(fifoQ[0][8]));
         checkOutput("rd_ferr", 32'(RD_FERR), 32'(fifoQ[0][9]));
      end
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic modelUpdate();
      int divE  = (int'(DIV) < 4) ? 4 : int'(DIV);
      bit doPop = RD_EN && (fifoQ.size() > 0);
      if (RXCT_R)
         nextCe = cyc + divE / 2;
      else if (cyc == nextCe)
         nextCe = cyc + divE;
      rxdHist.push_back(RXD);
      if (rxdHist.size() > 8) void'(rxdHist.pop_front());
      if (RX_DATA_EN && (fifoQ.size() == DEPTH) && !doPop)
         ovrM = 1'b1;
      else if (CLR_OVR)
         ovrM = 1'b0;
      if (doPop) void'(fifoQ.pop_front());
      if (RX_DATA_EN && (fifoQ.size() < DEPTH)) fifoQ.push_back(RX_DATA_T);
`ifdef UART_RX_ERR_CNT_EN
      if (CLR_CNT) begin
         perrM = 0;
         ferrM = 0;
      end else if (RX_DATA_EN) begin
         if (RX_DATA_T[8]) perrM = (perrM < 255) ? perrM + 1 : 255;
         if (RX_DATA_T[9]) ferrM = (ferrM < 255) ? ferrM + 1 : 255;
      end
`endif
   endtask

   task automatic applyStimulus();
      @(negedge CLK);
      checkAllOutputs();
      modelUpdate();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic setIdle();
      RXD        = 1'b1;
      RXCT_R     = 1'b1;
      RX_DATA_EN = 1'b0;
      RD_EN      = 1'b0;
      CLR_OVR    = 1'b0;
      CLR_CNT    = 1'b0;
   endtask

   task automatic resetDut();
      RST = 1'b1;
      setIdle();
      @(negedge CLK);
      checkOutput("rst_rxd_rg", 32'(RXD_RG), 32'd1);
      checkOutput("rst_rx_ce", 32'(RX_CE), 32'd0);
      checkOutput("rst_rd_valid", 32'(RD_VALID), 32'd0);
      checkOutput("rst_full", 32'(FULL), 32'd0);
      checkOutput("rst_rd_data", 32'(RD_DATA), 32'd0);
      checkOutput("rst_rd_perr", 32'(RD_PERR), 32'd0);
      checkOutput("rst_rd_ferr", 32'(RD_FERR), 32'd0);
      checkOutput("rst_ovr", 32'(OVR), 32'd0);
      checkOutput("rst_perr_cnt", 32'(PERR_CNT), 32'd0);
      checkOutput("rst_ferr_cnt", 32'(FERR_CNT), 32'd0);
      fifoQ.delete();
      rxdHist.delete();
      rxdHist.push_back(1'b1);
      rxdHist.push_back(1'b1);
      ovrM   = 1'b0;
      perrM  = 0;
      ferrM  = 0;
      nextCe = cyc;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      modelUpdate();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic pushWord(input logic [9:0] w, input bit withPop);
      RX_DATA_T  = w;
      RX_DATA_EN = 1'b1;
      RD_EN      = withPop;
      applyStimulus();
      RX_DATA_EN = 1'b0;
      RD_EN      = 1'b0;
      applyStimulus();
   endtask

   initial begin
      @(posedge CLK);
      #1;
      resetDut();

      // Strobe timing at DIV=16, then the clamped divisor DIV=2.
      DIV = 16'd16;
      repeat (3) applyStimulus();
      RXCT_R = 1'b0;
      repeat (40) applyStimulus();
      DIV    = 16'd2;
      RXCT_R = 1'b1;
      applyStimulus();
      RXCT_R = 1'b0;
      repeat (12) applyStimulus();
      RXCT_R = 1'b1;

      // Good word, parity error, framing error, then overrun with five frames unread.
      pushWord(10'h0A5, 1'b0);
      pushWord({2'b01, 8'h3C}, 1'b0);
      pushWord({2'b10, 8'h3C}, 1'b0);
      pushWord(10'({$urandom} % 256), 1'b0);
      pushWord(10'({$urandom} % 1024), 1'b0);
      CLR_OVR = 1'b1;
      applyStimulus();
      CLR_OVR = 1'b0;
      pushWord(10'h1E7, 1'b1);
      RD_EN = 1'b1;
      repeat (5) applyStimulus();
      RD_EN = 1'b0;

      // Two words queued and a frame in progress when reset hits.
      pushWord(10'h011, 1'b0);
      pushWord(10'h022, 1'b0);
      RXCT_R = 1'b0;
      repeat (5) applyStimulus();
      resetDut();
      pushWord(10'h055, 1'b0);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) DIV = 16'($urandom_range(0, 20));
         if ($urandom_range(0, 19) == 0) RXCT_R = ~RXCT_R;
         RXD        = 1'($urandom);
         RX_DATA_T  = 10'($urandom);
         RX_DATA_EN = ($urandom_range(0, 3) == 0);
         RD_EN      = ($urandom_range(0, 4) == 0);
         CLR_OVR    = ($urandom_range(0, 29) == 0);
         CLR_CNT    = ($urandom_range(0, 199) == 0);
         applyStimulus();
      end

      // Error counters run into saturation, then clear takes priority over an increment.
      setIdle();
      CLR_CNT = 1'b1;
      applyStimulus();
      CLR_CNT    = 1'b0;
      RX_DATA_EN = 1'b1;
      RD_EN      = 1'b1;
      for (int i = 0; i < 270; i++) begin
         RX_DATA_T = {2'b11, 8'($urandom)};
         applyStimulus();
      end
      CLR_CNT = 1'b1;
      applyStimulus();
      setIdle();
      repeat (4) applyStimulus();

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART RX bit FSM. It synchronises the serial pin and generates the FSM's bit-strobe `RX_CE` from a programmable baud divisor, phase-aligned to the FSM's counter-reset request `RXCT_R`. It also captures each completed 10-bit result word into a small FIFO with a first-word-fall-through read handshake and a sticky overrun flag. It sits between the pad, the RX FSM and the host-side consumer.

## Interface
- `FIFO_DEPTH`, 4: result FIFO depth; power of two, ≥2.
- `DIV_W`, 16: width of the baud divisor.
- `CLK` in 1: system clock.
- `RST` in 1: asynchronous, active-high reset.
- `RXD` in 1: asynchronous serial pin.
- `DIV` in DIV_W: clock cycles per bit; values <4 are treated as 4.
- `RXD_RG` out 1: synchronised serial data, to the FSM.
- `RX_CE` out 1: single-cycle bit strobe, to the FSM.
- `RXCT_R` in 1: from the FSM; 1 holds the bit timer in reset.
- `RX_DATA_T` in 10: FSM result; [7:0] data, [8] parity error, [9] framing error.
- `RX_DATA_EN` in 1: FSM one-cycle result-valid pulse.
- `RD_EN` in 1: consumer pop request.
- `RD_VALID` out 1: FIFO non-empty.
- `RD_DATA` out 8: head data.
- `RD_PERR` out 1: head parity-error flag.
- `RD_FERR` out 1: head framing-error flag.
- `FULL` out 1: FIFO full.
- `OVR` out 1: sticky overrun flag.
- `CLR_OVR` in 1: clears `OVR`.
- `PERR_CNT` out 8: saturating parity-error count (see Configuration).
- `FERR_CNT` out 8: saturating framing-error count (see Configuration).
- `CLR_CNT` in 1: clears both counters.

## Operation
- **Synchroniser:** two flops, both reset to 1. `RXD_RG` is the second flop.
- **Bit timer:** down-counter `CNT`, width DIV_W.
  - While `RXCT_R`=1: `CNT` <= (DIVe>>1)-1, where DIVe is the clamped divisor.
  - While `RXCT_R`=0 and `CNT`≠0: `CNT` decrements.
  - While `RXCT_R`=0 and `CNT`=0: `RX_CE`=1 for that cycle and `CNT` <= DIVe-1.
  - Result: the first strobe lands mid start bit, then one strobe per DIVe cycles.
  - `DIV` is sampled on every reload. A change takes effect at the next reload, never mid-count.
- **FIFO push:** on `RX_DATA_EN`, the full 10-bit word is written.
  - If the FIFO is full and no pop happens in the same cycle, the word is dropped and `OVR` is set.
  - If the FIFO is full and a pop happens in the same cycle, both operations succeed and `OVR` is unchanged.
- **FIFO pop:** `RD_EN` with `RD_VALID`=1 advances the head. `RD_EN` on an empty FIFO is ignored.
- **Head outputs:** `RD_DATA`/`RD_PERR`/`RD_FERR` always show the head entry. They are don't-care when `RD_VALID`=0.
- **Pointers:** read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
- **OVR:** a set event takes priority over `CLR_OVR` in the same cycle.
- **Reset values:**
  - `RX_CE`=0, `RXD_RG`=1.
  - FIFO empty: `RD_VALID`=0, `FULL`=0.
  - `RD_DATA`=0, `RD_PERR`=0, `RD_FERR`=0, `OVR`=0.
  - Both counters 0, `CNT`=0.
- **Reset mid-frame:** reset discards all FIFO contents and timer state. There is no partial recovery.

## Timing
- Pin to `RXD_RG`: 2 cycles.
- `RXCT_R` falling to first `RX_CE`: DIVe/2 cycles (the cycle in which `CNT` reaches 0 strobes).
- `RX_DATA_EN` to `RD_VALID` on an empty FIFO: 1 cycle (registered write, combinational read).
- Pop takes effect on the clock edge. The next head is visible in the following cycle.
- `FULL` and `RD_VALID` are derived combinationally from the registered pointers.

## Configuration
- `UART_RX_ERR_CNT_EN`:
  - **Defined:** `PERR_CNT`/`FERR_CNT` increment on each `RX_DATA_EN` whose bit 8 / bit 9 is set, and saturate at 255. Words dropped by overrun are still counted. `CLR_CNT` clears both counters and takes priority over an increment.
  - **Undefined:** no counter logic is built. `PERR_CNT`/`FERR_CNT` are tied to 0 and `CLR_CNT` is ignored.

## Structure
- **Package `uart_pkg`:**
  - RX word field indices: `RXW_PERR`=8, `RXW_FERR`=9, `RXW_DATA_MSB`=7.
  - `RX_DIV_MIN`=4.
  - `RX_WORD_W`=10.
- **Sub-module `uart_rx_fifo`:** parameterised synchronous FIFO with push, pop, full, empty and overrun. `uart_rx_ctrl` wraps it together with the synchroniser, the bit timer and the error counters.

## Test plan
- **Good frame:** bench instantiates this block with the RX FSM, `DIV`=16, and sends frame 0xA5 with correct parity.
  - `RD_VALID`=1, `RD_DATA`=0xA5, `RD_PERR`=0, `RD_FERR`=0.
  - The first `RX_CE` comes 8 cycles after `RXCT_R` falls; later strobes are 16 cycles apart.
- **Parity error, then framing error:** send 0x3C with a flipped parity bit, then 0x3C with stop bit = 0 held for 40 cycles.
  - FIFO holds {0x3C, PERR=1} then {0x3C, FERR=1}.
  - With the macro defined, `PERR_CNT`=1 and `FERR_CNT`=1.
- **Overrun:** `FIFO_DEPTH`=4, five frames with no reads.
  - `FULL`=1 after frame 4, `OVR`=1 after frame 5.
  - Reads return frames 1–4 in order.
  - `CLR_OVR` then clears `OVR`.
- **Push and pop on a full FIFO:** with the FIFO full, assert `RD_EN` in the same cycle as `RX_DATA_EN`.
  - No overrun, count stays 4, the new word is last in read order.
- **Divisor clamp and glitch:** `DIV`=2 behaves exactly like `DIV`=4.
  - A 1-cycle low pulse on `RXD` mid-idle: the FSM aborts at the first `RX_CE`, `RXCT_R` returns to 1, nothing is pushed.
- **Reset mid-frame:** assert `RST` during the data bits with 2 words queued.
  - All outputs return to their reset values.
  - The next clean frame 0x55 is received correctly.
